// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encoding and WIDTH bounds.
// No logic, no latency; imported by the multiplier top.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/adder_n.sv
// N-bit ripple-carry adder chained from full_adder cells.
// Combinational, zero latency, no handshake.
module adder_n #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (carry[i]),
      .sum (sum[i]),
      .cout(carry[i+1])
    );
  end

  assign cout = carry[N];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell, purely combinational (zero latency, no handshake).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign sum  = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/seq_multiplier_n.sv
// Shift-add multiplier, unsigned or two's complement per transaction; WIDTH cycles accept-to-result.
// Accepts only in IDLE; the result is held in DONE for as long as out_ready stays low.
module seq_multiplier_n
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("seq_multiplier_n: WIDTH outside legal range");
  end

  state_t               state_q, state_d;
  logic [2*WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic                 out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       addend, add_sum;
  logic                 add_co;
  logic [2*WIDTH+1:0]   acc_wide;
  logic [2*WIDTH:0]     acc_shift;
  logic [2*WIDTH-1:0]   prod_mag;
  logic                 last_bit;

  // -2^(WIDTH-1) negates to itself, which read unsigned is the correct magnitude.
  assign a_mag = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_mag = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

  assign addend = mplier_q[0] ? {1'b0, mcand_q} : '0;

  adder_n #(.N(WIDTH + 1)) u_add (
    .a   (acc_q[2*WIDTH:WIDTH]),
    .b   (addend),
    .cin (1'b0),
    .sum (add_sum),
    .cout(add_co)
  );

  assign acc_wide  = {add_co, add_sum, acc_q[WIDTH-1:0]};
  assign acc_shift = (2*WIDTH+1)'(acc_wide >> 1);
  assign prod_mag  = acc_shift[2*WIDTH-1:0];
  assign last_bit  = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    out_valid_d = out_valid_q;
    product_d   = product_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        acc_d    = acc_shift;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last_bit) begin
          product_d   = neg_q ? (~prod_mag + (2*WIDTH)'(1)) : prod_mag;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      product_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
      product_q   <= product_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule

// File: tb/tb_seq_multiplier_n.sv
// Self-checking bench: four multiplier instances (WIDTH 2/4/8/16) sharing clock, reset and operand buses.
module tb_seq_multiplier_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a, b;
  logic        signed_mode;
  logic        in_valid_w  [4];
  logic        in_ready_w  [4];
  logic        out_valid_w [4];
  logic        out_ready_w [4];
  logic [31:0] prod_w      [4];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 4; i++) begin : g_dut
    localparam int W = 2 << i;
    logic [2*W-1:0] p;

    seq_multiplier_n #(.WIDTH(W)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid_w[i]),
      .in_ready   (in_ready_w[i]),
      .a          (a[W-1:0]),
      .b          (b[W-1:0]),
      .signed_mode(signed_mode),
      .out_valid  (out_valid_w[i]),
      .out_ready  (out_ready_w[i]),
      .product    (p)
    );

    assign prod_w[i] = 32'(p);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: interpret operands as plain integers and multiply.
  function automatic logic [31:0] ref_mul(input int w, input logic [15:0] av, input logic [15:0] bv,
                                          input bit sm);
    longint sa, sb, p, mask;
    mask = (64'sd1 <<< w) - 1;
    sa = longint'(av) & mask;
    sb = longint'(bv) & mask;
    if (sm && av[w-1]) sa = sa - (64'sd1 <<< w);
    if (sm && bv[w-1]) sb = sb - (64'sd1 <<< w);
    p = sa * sb;
    return 32'(p & ((64'sd1 <<< (2 * w)) - 1));
  endfunction

  task automatic txn(input int k, input logic [15:0] av, input logic [15:0] bv, input bit sm,
                     input logic [31:0] exp, input int pre, input int hold, input string tag);
    int w, lat;
    w = 2 << k;
    repeat (pre) @(negedge clk);
    a = av; b = bv; signed_mode = sm;
    in_valid_w[k] = 1'b1;
    chk({tag, "_in_ready_idle"}, in_ready_w[k], 1);
    @(posedge clk);
    @(negedge clk);
    in_valid_w[k] = 1'b0;
    a = 16'($urandom); b = 16'($urandom); signed_mode = 1'($urandom);
    lat = 0;
    while (!out_valid_w[k] && lat < 200) begin
      in_valid_w[k] = ($urandom % 3 == 0);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, w);
    chk({tag, "_product"}, prod_w[k], exp);
    chk({tag, "_in_ready_done"}, in_ready_w[k], 0);
    for (int h = 0; h < hold; h++) begin
      in_valid_w[k] = 1'($urandom);
      a = 16'($urandom); b = 16'($urandom);
      @(negedge clk);
      chk({tag, "_hold_valid"}, out_valid_w[k], 1);
      chk({tag, "_hold_product"}, prod_w[k], exp);
      chk({tag, "_hold_in_ready"}, in_ready_w[k], 0);
    end
    in_valid_w[k]  = 1'b0;
    out_ready_w[k] = 1'b1;
    @(negedge clk);
    out_ready_w[k] = 1'b0;
    chk({tag, "_valid_cleared"}, out_valid_w[k], 0);
    chk({tag, "_idle_again"}, in_ready_w[k], 1);
    chk({tag, "_product_kept"}, prod_w[k], exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] av, bv;
    bit          sm;

    rst_n = 1'b0;
    a = '0; b = '0; signed_mode = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid_w[k]  = 1'b0;
      out_ready_w[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset_in_ready_%0d", k), in_ready_w[k], 1);
      chk($sformatf("reset_out_valid_%0d", k), out_valid_w[k], 0);
      chk($sformatf("reset_product_%0d", k), prod_w[k], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    txn(1, 16'd15, 16'd15, 1'b0, 32'h00E1, 0, 0, "u4_15x15");
    txn(1, 16'h8, 16'd7, 1'b1, 32'h00C8, 0, 0, "s4_m8x7");
    txn(1, 16'h8, 16'h8, 1'b1, 32'h0040, 1, 0, "s4_m8xm8");
    txn(2, 16'h80, 16'h80, 1'b1, 32'h4000, 0, 0, "s8_m128sq");
    txn(2, 16'h00, 16'hFF, 1'b1, 32'h0000, 0, 0, "s8_0xm1");
    txn(2, 16'd200, 16'd3, 1'b0, 32'h0258, 0, 5, "u8_backpressure");

    // Reset two cycles into BUSY discards the in-flight result.
    a = 16'd15; b = 16'd15; signed_mode = 1'b0;
    in_valid_w[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_w[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("rst_busy_before", in_ready_w[1], 0);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid_w[1], 0);
    chk("rst_product", prod_w[1], 0);
    chk("rst_in_ready", in_ready_w[1], 1);
    @(negedge clk);
    rst_n = 1'b1;
    txn(1, 16'd3, 16'd5, 1'b0, 32'd15, 1, 0, "after_rst_3x5");

    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 40; n++) begin
        av = 16'($urandom);
        bv = 16'($urandom);
        sm = 1'($urandom);
        txn(k, av, bv, sm, ref_mul(2 << k, av, bv, sm), int'($urandom % 3), int'($urandom % 4),
            $sformatf("rnd_w%0d_%0d", 2 << k, n));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
